// File: rtl/inverse_sched.sv
// inverse_sched
//   Phase sequencer and shared-multiplier arbiter for the inverse pipeline.
//   Runs the master phase counter (0..MAX-1), issues the mat_mult phase-reset
//   pulses and mat_mode select, and arbitrates the single array_mult between
//   the cholesky_block (req[0]) and lt_block (req[1]) requesters.
//
// Ports
//   clk      in   1   clock, rising edge
//   rst      in   1   asynchronous active-high reset
//   en       in   1   pipeline advance; low freezes every register
//   start    in   1   level run request, sampled in IDLE and at the wrap edge
//   busy     out  1   high while in RUN
//   done     out  1   one en-cycle pulse at the end of a run
//   count    out  CW  current phase count
//   mat_rst  out  1   registered reset to mat_mult
//   mat_mode out  1   0 = array mode, 1 = matrix mode
//   req      in   2   multiplier requests: [0] cholesky, [1] lt
//   gnt      out  2   registered one-hot (or zero) grant
//   mult_sel out  1   array_mult operand mux select (gnt[1])
module inverse_sched #(
  parameter int MAX     = 229,
  parameter int CW      = 8,
  parameter int RST_A   = 28,
  parameter int RST_B   = 98,
  parameter int RST_C   = 214,
  parameter int MODE_LO = 89,
  parameter int MODE_HI = 98
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] count,
  output logic          mat_rst,
  output logic          mat_mode,
  input  logic [1:0]    req,
  output logic [1:0]    gnt,
  output logic          mult_sel
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [CW-1:0] CNT_LAST = CW'(MAX - 1);
  localparam logic [CW-1:0] CNT_A    = CW'(RST_A);
  localparam logic [CW-1:0] CNT_B    = CW'(RST_B);
  localparam logic [CW-1:0] CNT_C    = CW'(RST_C);
  localparam logic [CW-1:0] CNT_LO   = CW'(MODE_LO);
  localparam logic [CW-1:0] CNT_HI   = CW'(MODE_HI);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] count_nxt;
  logic          done_nxt;
  logic          mat_rst_nxt;
  logic [1:0]    gnt_nxt;
  // Last grantee: 1'b0 = cholesky, 1'b1 = lt.
  logic          last;
  logic          last_nxt;
  logic          other;

  // State, counter, pulse and grant registers; en low holds everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      done    <= 1'b0;
      mat_rst <= 1'b0;
      gnt     <= 2'b00;
      last    <= 1'b1;
    end else if (en) begin
      state   <= state_nxt;
      count   <= count_nxt;
      done    <= done_nxt;
      mat_rst <= mat_rst_nxt;
      gnt     <= gnt_nxt;
      last    <= last_nxt;
    end
  end

  // Sequencer next-state: count wraps at MAX-1 (not 2**CW); start at the
  // wrap edge chains straight into the next run with no IDLE gap.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        count_nxt = '0;
        if (start) begin
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        if (count == CNT_LAST) begin
          count_nxt = '0;
          done_nxt  = 1'b1;
          if (start) begin
            state_nxt = RUN;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          count_nxt = count + CW'(1);
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = IDLE;
        count_nxt = '0;
      end
    endcase
  end

  // mat_mult reset lands one cycle after the matching count.
  always_comb begin
    mat_rst_nxt = 1'b0;
    if (state == RUN) begin
      mat_rst_nxt = (count == CNT_A) || (count == CNT_B) || (count == CNT_C);
    end else begin
      mat_rst_nxt = 1'b0;
    end
  end

  // Locked round-robin arbiter: an owner that keeps requesting keeps the
  // grant; otherwise the non-last requester is preferred. The pointer only
  // moves when the grant passes to the other requester.
  always_comb begin
    gnt_nxt  = 2'b00;
    last_nxt = last;
    other    = ~last;
    if (gnt[0] && req[0]) begin
      gnt_nxt = 2'b01;
    end else if (gnt[1] && req[1]) begin
      gnt_nxt = 2'b10;
    end else if (req[other]) begin
      gnt_nxt  = other ? 2'b10 : 2'b01;
      last_nxt = other;
    end else if (req[last]) begin
      gnt_nxt = last ? 2'b10 : 2'b01;
    end else begin
      gnt_nxt = 2'b00;
    end
  end

  // Decoded outputs straight from the state and count registers.
  always_comb begin
    busy     = (state == RUN);
    mat_mode = !((state == RUN) && (count >= CNT_LO) && (count < CNT_HI));
    mult_sel = gnt[1];
  end

endmodule

// File: tb/tb_inverse_sched.sv
// tb_inverse_sched
//   Directed bench for inverse_sched: full runs with en high, en toggling,
//   back-to-back runs with start held, async reset mid-run, and a table of
//   arbiter request/grant vectors.
module tb_inverse_sched;

  logic       clk;
  logic       rst;
  logic       en;
  logic       start;
  logic       busy;
  logic       done;
  logic [7:0] count;
  logic       mat_rst;
  logic       mat_mode;
  logic [1:0] req;
  logic [1:0] gnt;
  logic       mult_sel;

  int total;
  int bad;

  typedef struct packed {
    logic       en;
    logic [1:0] req;
    logic [1:0] gnt;
  } arb_vec_t;

  arb_vec_t vecs [17];

  inverse_sched dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .count    (count),
    .mat_rst  (mat_rst),
    .mat_mode (mat_mode),
    .req      (req),
    .gnt      (gnt),
    .mult_sel (mult_sel)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected mat_rst once count has just become n during a run.
  function automatic logic exp_mr(input int n);
    return (n == 29) || (n == 99) || (n == 215);
  endfunction

  // Expected mat_mode while running at count n.
  function automatic logic exp_mm(input int n);
    return !((n >= 89) && (n <= 97));
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " busy"},     32'(busy),     32'd0);
    chk({tag, " done"},     32'(done),     32'd0);
    chk({tag, " count"},    32'(count),    32'd0);
    chk({tag, " mat_rst"},  32'(mat_rst),  32'd0);
    chk({tag, " mat_mode"}, 32'(mat_mode), 32'd1);
    chk({tag, " gnt"},      32'(gnt),      32'd0);
    chk({tag, " mult_sel"}, 32'(mult_sel), 32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;

    vecs[0]  = '{en: 1'b1, req: 2'b11, gnt: 2'b01};
    vecs[1]  = '{en: 1'b1, req: 2'b11, gnt: 2'b01};
    vecs[2]  = '{en: 1'b1, req: 2'b10, gnt: 2'b10};
    vecs[3]  = '{en: 1'b1, req: 2'b11, gnt: 2'b10};
    vecs[4]  = '{en: 1'b1, req: 2'b01, gnt: 2'b01};
    vecs[5]  = '{en: 1'b1, req: 2'b00, gnt: 2'b00};
    vecs[6]  = '{en: 1'b1, req: 2'b11, gnt: 2'b10};
    vecs[7]  = '{en: 1'b1, req: 2'b00, gnt: 2'b00};
    vecs[8]  = '{en: 1'b1, req: 2'b01, gnt: 2'b01};
    vecs[9]  = '{en: 1'b1, req: 2'b00, gnt: 2'b00};
    vecs[10] = '{en: 1'b1, req: 2'b01, gnt: 2'b01};
    vecs[11] = '{en: 1'b1, req: 2'b00, gnt: 2'b00};
    vecs[12] = '{en: 1'b1, req: 2'b10, gnt: 2'b10};
    vecs[13] = '{en: 1'b0, req: 2'b01, gnt: 2'b10};
    vecs[14] = '{en: 1'b1, req: 2'b01, gnt: 2'b01};
    vecs[15] = '{en: 1'b1, req: 2'b11, gnt: 2'b01};
    vecs[16] = '{en: 1'b1, req: 2'b10, gnt: 2'b10};

    // Reset state
    rst   = 1'b1;
    en    = 1'b0;
    start = 1'b0;
    req   = 2'b00;
    step();
    step();
    chk_reset_outputs("reset");
    rst = 1'b0;
    en  = 1'b1;
    step();
    chk_reset_outputs("idle");

    // Single run, en high; a start pulse mid-run must be ignored
    start = 1'b1;
    step();
    chk("run1 busy first", 32'(busy), 32'd1);
    chk("run1 count first", 32'(count), 32'd0);
    chk("run1 done first", 32'(done), 32'd0);
    for (int i = 1; i <= 228; i++) begin
      start = (i == 50);
      step();
      chk("run1 count", 32'(count), 32'(i));
      chk("run1 busy", 32'(busy), 32'd1);
      chk("run1 done", 32'(done), 32'd0);
      chk("run1 mat_rst", 32'(mat_rst), 32'(exp_mr(i)));
      chk("run1 mat_mode", 32'(mat_mode), 32'(exp_mm(i)));
    end
    start = 1'b0;
    step();
    chk("run1 wrap count", 32'(count), 32'd0);
    chk("run1 wrap done", 32'(done), 32'd1);
    chk("run1 wrap busy", 32'(busy), 32'd0);
    chk("run1 wrap mat_mode", 32'(mat_mode), 32'd1);
    step();
    chk("run1 after done", 32'(done), 32'd0);
    chk("run1 after busy", 32'(busy), 32'd0);
    chk("run1 after count", 32'(count), 32'd0);

    // en toggling every cycle: every value holds through the stall cycle
    start = 1'b1;
    step();
    chk("tog busy first", 32'(busy), 32'd1);
    chk("tog count first", 32'(count), 32'd0);
    start = 1'b0;
    for (int i = 1; i <= 228; i++) begin
      en = 1'b0;
      step();
      chk("tog hold count", 32'(count), 32'(i - 1));
      chk("tog hold mat_rst", 32'(mat_rst), 32'(exp_mr(i - 1)));
      chk("tog hold done", 32'(done), 32'd0);
      en = 1'b1;
      step();
      chk("tog count", 32'(count), 32'(i));
      chk("tog mat_rst", 32'(mat_rst), 32'(exp_mr(i)));
      chk("tog mat_mode", 32'(mat_mode), 32'(exp_mm(i)));
    end
    en = 1'b0;
    step();
    chk("tog pre-wrap count", 32'(count), 32'd228);
    chk("tog pre-wrap done", 32'(done), 32'd0);
    en = 1'b1;
    step();
    chk("tog wrap done", 32'(done), 32'd1);
    chk("tog wrap busy", 32'(busy), 32'd0);
    en = 1'b0;
    step();
    chk("tog done held", 32'(done), 32'd1);
    en = 1'b1;
    step();
    chk("tog done cleared", 32'(done), 32'd0);

    // start held: back-to-back runs with no IDLE cycle
    start = 1'b1;
    req   = 2'b10;
    step();
    chk("b2b busy first", 32'(busy), 32'd1);
    chk("b2b count first", 32'(count), 32'd0);
    for (int i = 1; i <= 228; i++) begin
      step();
      chk("b2b count", 32'(count), 32'(i));
      chk("b2b busy", 32'(busy), 32'd1);
    end
    step();
    chk("b2b wrap count", 32'(count), 32'd0);
    chk("b2b wrap done", 32'(done), 32'd1);
    chk("b2b wrap busy", 32'(busy), 32'd1);
    step();
    chk("b2b second count", 32'(count), 32'd1);
    chk("b2b second done", 32'(done), 32'd0);
    chk("b2b second busy", 32'(busy), 32'd1);
    for (int i = 2; i <= 100; i++) begin
      step();
    end
    chk("b2b count before rst", 32'(count), 32'd100);
    chk("b2b gnt before rst", 32'(gnt), 32'd2);
    chk("b2b mult_sel before rst", 32'(mult_sel), 32'd1);

    // Async reset mid-run at count 100
    #2;
    rst   = 1'b1;
    start = 1'b0;
    req   = 2'b00;
    #1;
    chk_reset_outputs("async rst");
    step();
    chk_reset_outputs("rst held");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post-rst done", 32'(done), 32'd0);
      chk("post-rst busy", 32'(busy), 32'd0);
      chk("post-rst count", 32'(count), 32'd0);
    end
    start = 1'b1;
    step();
    chk("resume busy", 32'(busy), 32'd1);
    chk("resume count", 32'(count), 32'd0);
    start = 1'b0;
    step();
    chk("resume count next", 32'(count), 32'd1);

    // Arbiter vectors, pointer fresh from reset
    for (int v = 0; v < 17; v++) begin
      en  = vecs[v].en;
      req = vecs[v].req;
      step();
      chk($sformatf("arb gnt v%0d", v), 32'(gnt), 32'(vecs[v].gnt));
      chk($sformatf("arb mult_sel v%0d", v), 32'(mult_sel), 32'(vecs[v].gnt[1]));
    end
    en  = 1'b1;
    req = 2'b00;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
